// File: rtl/regfile_pkg.sv
// Shared constants for the two-read/one-write MIPS register file.
package regfile_pkg;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  // r0 has no storage and always reads as zero
  localparam logic [4:0] ZERO_REG = 5'd0;

  // True when register idx is the target of an enabled write
  function automatic logic write_hit(input logic             reg_write,
                                     input logic [ADDR_WIDTH-1:0] wr_addr,
                                     input logic [ADDR_WIDTH-1:0] idx);
    return reg_write & (wr_addr == idx);
  endfunction

endpackage

// File: rtl/regfile_register32.sv
// WIDTH-bit D register with write enable and asynchronous active-high reset.
module register32
  import regfile_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next state: load new data when enabled, otherwise hold
  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end else begin
      data_d = data_q;
    end
  end

  // Storage flop; reset clears immediately without a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= {W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port, r0 hard-wired to zero. No read/write bypass: forwarding is
// handled by the downstream operand muxes.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH      = regfile_pkg::WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] regs_s [DEPTH];
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;

  // Input 0 of both read selects is the constant-zero r0
  assign regs_s[ZERO_REG] = {WIDTH{1'b0}};

  genvar i;
  generate
    for (i = 1; i < DEPTH; i++) begin : g_reg
      logic en_s;
      assign en_s = write_hit(RegWrite, WriteRegister, ADDR_WIDTH'(i));

      register32 #(.W(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (en_s),
        .d_i   (WriteData),
        .q_o   (regs_s[i])
      );
    end
  endgenerate

  // Read port 1: 32:1 select from current register state
  always_comb begin
    rd1_s = regs_s[ReadRegister1];
  end

  // Read port 2: 32:1 select from current register state
  always_comb begin
    rd2_s = regs_s[ReadRegister2];
  end

  assign ReadData1 = rd1_s;
  assign ReadData2 = rd2_s;

endmodule

// File: tb/tb_regfile.sv
// Directed + scoreboard testbench for regfile.
module tb_regfile;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  logic [31:0] model [32];
  logic [31:0] sb [$];
  int n_pass;
  int n_total;

  regfile dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s: scoreboard empty, got %h", tag, obs);
    end else begin
      exp = sb.pop_front();
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Push model expectations, drive read addresses, then compare after settle
  task automatic sample(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    sb.push_back(model[a1]);
    sb.push_back(model[a2]);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
    check({tag, "_p1"}, ReadData1);
    check({tag, "_p2"}, ReadData2);
  endtask

  task automatic do_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    RegWrite      = we;
    WriteRegister = a;
    WriteData     = d;
    @(posedge clk);
    if (we && a != 5'd0 && !reset) model[a] = d;
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) model[k] = 32'h0000_0000;
  endtask

  initial begin
    logic [4:0]  ra;
    logic [4:0]  prev_a;
    logic [31:0] rd;
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    RegWrite = 1'b0;
    WriteRegister = 5'd0;
    WriteData = 32'h0000_0000;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    clear_model();

    #2;
    sample("in_reset", 5'd5, 5'd17);
    @(negedge clk);
    reset = 1'b0;

    // Every address reads zero after reset on both ports
    for (int i = 0; i < 32; i++) begin
      sample("post_reset", 5'(i), 5'(31 - i));
    end

    // Basic write/read; first write lands on first edge after release
    do_write(1'b1, 5'd5, 32'hA3C9_72C4);
    do_write(1'b1, 5'd17, 32'h144C_AB32);
    sample("basic", 5'd5, 5'd17);

    // r0 immutability
    do_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    sample("r0", 5'd0, 5'd0);
    sample("r0_nodisturb", 5'd5, 5'd17);

    // Write-enable gating
    do_write(1'b1, 5'd9, 32'h5555_5555);
    do_write(1'b0, 5'd9, 32'hAAAA_AAAA);
    sample("we_gate", 5'd9, 5'd9);

    // Read-during-write: old value before the edge, new value after
    do_write(1'b1, 5'd3, 32'h18ED_932B);
    @(negedge clk);
    RegWrite = 1'b1;
    WriteRegister = 5'd3;
    WriteData = 32'h714A_0DC2;
    sample("rdw_before", 5'd3, 5'd3);
    @(posedge clk);
    model[3] = 32'h714A_0DC2;
    #1;
    RegWrite = 1'b0;
    sample("rdw_after", 5'd3, 5'd3);

    // Pseudo-random writes, each read back alongside the previous target
    prev_a = 5'd5;
    for (int i = 0; i < 10; i++) begin
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      do_write(1'b1, ra, rd);
      sample("rand", ra, prev_a);
      prev_a = ra;
    end

    // Async reset mid-operation with a pending write to r31
    do_write(1'b1, 5'd31, 32'hD132_AB67);
    @(negedge clk);
    RegWrite = 1'b1;
    WriteRegister = 5'd31;
    WriteData = 32'h842E_2067;
    sample("pre_areset", 5'd31, 5'd9);
    #1;
    reset = 1'b1;
    clear_model();
    sample("areset_now", 5'd31, 5'd5);
    @(posedge clk);
    #1;
    sample("areset_edge", 5'd31, 5'd3);
    @(negedge clk);
    reset = 1'b0;
    RegWrite = 1'b0;
    @(posedge clk);
    #1;
    sample("after_release", 5'd31, 5'd17);

    // Writes work again after release
    do_write(1'b1, 5'd31, 32'h0BAD_F00D);
    sample("rewrite", 5'd31, 5'd0);

    if (sb.size() != 0) begin
      n_total++;
      $error("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
